// File: rtl/branch_update_issuer.sv
// branch_update_issuer
// Queues resolved branches from the FD stage and replays them to the branch
// predictor as single-cycle update strobes. Strobes are always separated by
// at least one idle cycle. Also keeps saturating resolved-branch and
// misprediction counters.
module branch_update_issuer #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [PC_W-1:0]  res_pc,
  input  logic             res_taken,
  input  logic             res_predicted,
  input  logic             flush,
  output logic             upd_flag,
  output logic             upd_taken,
  output logic [PC_W-1:0]  upd_pc,
  output logic             busy,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int E_W = PC_W + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic [E_W-1:0]   mem_reg [DEPTH];
  logic [DEPTH-1:0] we_vec;
  logic             full, empty, push, pop;

  logic [E_W-1:0]   rd_entry;
  logic [PC_W-1:0]  rd_pc;
  logic             rd_taken, rd_predicted;

  logic             upd_flag_reg, upd_flag_next;
  logic             upd_taken_reg, upd_taken_next;
  logic [PC_W-1:0]  upd_pc_reg, upd_pc_next;
  logic [CNT_W-1:0] branch_count_reg, branch_count_next;
  logic [CNT_W-1:0] mispredict_count_reg, mispredict_count_next;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // No pop-through: a full FIFO refuses even when it drains this cycle.
  // Holding ready low while rst is asserted keeps the producer quiet in reset.
  assign res_ready = rst & ~full & ~flush;
  assign push      = res_valid & res_ready;

  // Per-entry write enables decoded from the write pointer.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign we_vec[gi] = push && (wr_ptr_reg[AW-1:0] == AW'(gi));
    end
  endgenerate

  // FIFO storage; contents need no reset since pointers gate validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we_vec[i]) mem_reg[i] <= {res_pc, res_taken, res_predicted};
    end
  end

  assign rd_entry     = mem_reg[rd_ptr_reg[AW-1:0]];
  assign rd_pc        = rd_entry[E_W-1:2];
  assign rd_taken     = rd_entry[1];
  assign rd_predicted = rd_entry[0];

  // Pointer update; flush empties the queue by realigning both pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // FSM next state; a pop happens only outside ISSUE, which forces the gap.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!empty && !flush) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_next = flush ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (!empty && !flush) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output next values: strobe follows ISSUE, payload and counters move on pop.
  always_comb begin
    upd_flag_next         = (state_next == S_ISSUE);
    upd_pc_next           = upd_pc_reg;
    upd_taken_next        = upd_taken_reg;
    branch_count_next     = branch_count_reg;
    mispredict_count_next = mispredict_count_reg;
    if (pop) begin
      upd_pc_next    = rd_pc;
      upd_taken_next = rd_taken;
      if (branch_count_reg != {CNT_W{1'b1}})
        branch_count_next = branch_count_reg + 1'b1;
      if ((rd_taken != rd_predicted) && (mispredict_count_reg != {CNT_W{1'b1}}))
        mispredict_count_next = mispredict_count_reg + 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_flag_reg         <= 1'b0;
      upd_taken_reg        <= 1'b0;
      upd_pc_reg           <= '0;
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      upd_flag_reg         <= upd_flag_next;
      upd_taken_reg        <= upd_taken_next;
      upd_pc_reg           <= upd_pc_next;
      branch_count_reg     <= branch_count_next;
      mispredict_count_reg <= mispredict_count_next;
    end
  end

  assign upd_flag         = upd_flag_reg;
  assign upd_taken        = upd_taken_reg;
  assign upd_pc           = upd_pc_reg;
  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;
  assign busy             = ~empty | (state_reg != S_IDLE);

endmodule

// File: tb/tb_branch_update_issuer.sv
// Testbench for branch_update_issuer: a directed table, hand-written corner
// sequences and a random run, all checked against a queue-based model.
module tb_branch_update_issuer;

  localparam int PC_W  = 10;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            res_valid = 1'b0;
  logic [PC_W-1:0] res_pc = '0;
  logic            res_taken = 1'b0;
  logic            res_predicted = 1'b0;
  logic            flush = 1'b0;

  logic            res_ready, upd_flag, upd_taken, busy;
  logic [PC_W-1:0] upd_pc;
  logic [15:0]     branch_count, mispredict_count;

  logic            s_ready, s_flag, s_taken, s_busy;
  logic [PC_W-1:0] s_pc;
  logic [3:0]      s_bc, s_mc;

  always #5 clk = ~clk;

  branch_update_issuer #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_pc(res_pc), .res_taken(res_taken), .res_predicted(res_predicted),
    .flush(flush), .upd_flag(upd_flag), .upd_taken(upd_taken), .upd_pc(upd_pc),
    .busy(busy), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  // Narrow-counter instance sharing all stimulus, used for saturation checks.
  branch_update_issuer #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(s_ready),
    .res_pc(res_pc), .res_taken(res_taken), .res_predicted(res_predicted),
    .flush(flush), .upd_flag(s_flag), .upd_taken(s_taken), .upd_pc(s_pc),
    .busy(s_busy), .branch_count(s_bc), .mispredict_count(s_mc)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [PC_W-1:0] pc;
    logic            t;
    logic            p;
  } ent_t;

  ent_t            q[$];
  logic            m_flag, m_gap, m_taken;
  logic [PC_W-1:0] m_pc;
  int              m_bc, m_mc, m_bc4, m_mc4;

  logic ready_seen, accepted, pre_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_flag = 0; m_gap = 0; m_taken = 0; m_pc = '0;
    m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
  endtask

  // One clock edge of the model: an update may leave only while no strobe is
  // showing, and a new entry may enter only when there is room and no flush.
  task automatic model_edge(input logic v, input logic [PC_W-1:0] pc,
                            input logic t, input logic p, input logic f);
    logic do_pop, do_push;
    ent_t e;
    do_pop  = !m_flag && (q.size() > 0) && !f;
    do_push = v && (q.size() < DEPTH) && !f;
    m_gap   = m_flag && !f;
    m_flag  = do_pop;
    if (f) begin
      q.delete();
    end else begin
      if (do_pop) begin
        e = q.pop_front();
        m_pc = e.pc; m_taken = e.t;
        if (m_bc < 65535) m_bc++;
        if (m_bc4 < 15) m_bc4++;
        if (e.t != e.p) begin
          if (m_mc < 65535) m_mc++;
          if (m_mc4 < 15) m_mc4++;
        end
      end
      if (do_push) begin
        e.pc = pc; e.t = t; e.p = p;
        q.push_back(e);
      end
    end
  endtask

  task automatic check_outputs();
    chk("upd_flag",   upd_flag,  m_flag);
    chk("upd_pc",     upd_pc,    m_pc);
    chk("upd_taken",  upd_taken, m_taken);
    chk("busy",       busy,      (q.size() > 0) || m_flag || m_gap);
    chk("branch_count",     branch_count,     m_bc);
    chk("mispredict_count", mispredict_count, m_mc);
    chk("sat_flag",   s_flag, m_flag);
    chk("sat_branch_count",     s_bc, m_bc4);
    chk("sat_mispredict_count", s_mc, m_mc4);
  endtask

  // Drive one cycle of inputs, check ready before the edge and outputs after.
  task automatic step(input logic v, input logic [PC_W-1:0] pc,
                      input logic t, input logic p, input logic f);
    res_valid = v; res_pc = pc; res_taken = t; res_predicted = p; flush = f;
    #1;
    ready_seen = res_ready;
    chk("res_ready", res_ready, (q.size() < DEPTH) && !f);
    accepted = v && res_ready;
    pre_pop  = !m_flag && (q.size() > 0) && !f;
    @(posedge clk);
    model_edge(v, pc, t, p, f);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    res_valid = 0; flush = 0;
    @(negedge clk);
    chk("reset_ready", res_ready, 0);
    chk("reset_flag",  upd_flag, 0);
    chk("reset_busy",  busy, 0);
    chk("reset_pc",    upd_pc, 0);
    chk("reset_bc",    branch_count, 0);
    chk("reset_mc",    mispredict_count, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic            v;
    logic [PC_W-1:0] pc;
    logic            t, p, f;
    logic            e_ready, e_flag;
    logic [PC_W-1:0] e_pc;
    logic            e_taken, e_busy;
    logic [15:0]     e_bc, e_mc;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [PC_W-1:0] issued[$];
    logic [PC_W-1:0] exp_pc;
    logic            saw_full, prev_block;
    int              idx, saved_bc, saved_mc, pulses;

    // Single mispredicted branch: pushed at edge 0, strobed after edge 1.
    tbl[0] = '{1, 10'h025, 1, 0, 0,  1, 0, 10'h000, 0, 1, 16'd0, 16'd0};
    tbl[1] = '{0, 10'h000, 0, 0, 0,  1, 1, 10'h025, 1, 1, 16'd1, 16'd1};
    tbl[2] = '{0, 10'h000, 0, 0, 0,  1, 0, 10'h025, 1, 1, 16'd1, 16'd1};
    tbl[3] = '{0, 10'h000, 0, 0, 0,  1, 0, 10'h025, 1, 0, 16'd1, 16'd1};
    tbl[4] = '{0, 10'h000, 0, 0, 0,  1, 0, 10'h025, 1, 0, 16'd1, 16'd1};

    model_reset();
    do_reset();

    for (int i = 0; i < 5; i++) begin
      step(tbl[i].v, tbl[i].pc, tbl[i].t, tbl[i].p, tbl[i].f);
      chk("tbl_ready", ready_seen, tbl[i].e_ready);
      chk("tbl_flag",  upd_flag,   tbl[i].e_flag);
      chk("tbl_pc",    upd_pc,     tbl[i].e_pc);
      chk("tbl_taken", upd_taken,  tbl[i].e_taken);
      chk("tbl_busy",  busy,       tbl[i].e_busy);
      chk("tbl_bc",    branch_count,     tbl[i].e_bc);
      chk("tbl_mc",    mispredict_count, tbl[i].e_mc);
      $display("table row %0d: flag=%0b pc=%03h busy=%0b bc=%0d mc=%0d",
               i, upd_flag, upd_pc, busy, branch_count, mispredict_count);
    end

    // Held valid stream fills the FIFO; order, pacing and full behaviour.
    do_reset();
    idx = 0; saw_full = 0; prev_block = 0;
    for (int c = 0; c < 40; c++) begin
      if (idx < 10) step(1'b1, PC_W'(10'h010 + idx), idx[0], 1'b1, 1'b0);
      else          step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (prev_block) chk("push_after_full_pop", accepted, 1);
      prev_block = (idx < 10) && !ready_seen && pre_pop;
      if (prev_block) saw_full = 1;
      if (accepted) idx++;
      if (upd_flag) issued.push_back(upd_pc);
    end
    chk("stream_full_seen", saw_full, 1);
    chk("stream_issued", issued.size(), 10);
    for (int i = 0; i < issued.size(); i++) begin
      exp_pc = PC_W'(10'h010 + i);
      chk("stream_order", issued[i], exp_pc);
    end
    chk("stream_bc", branch_count, 10);
    $display("stream: issued=%0d bc=%0d", issued.size(), branch_count);

    // Flush while a strobe is showing and entries are still queued.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, PC_W'(10'h100 + i), 1'b1, 1'b1, 1'b0);
    chk("flush_pre_flag", upd_flag, 1);
    saved_bc = branch_count; saved_mc = mispredict_count;
    step(1'b1, 10'h1FF, 1'b0, 1'b1, 1'b1);
    chk("flush_flag_drop", upd_flag, 0);
    chk("flush_busy", busy, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (upd_flag) pulses++;
    end
    chk("flush_no_pulses", pulses, 0);
    chk("flush_bc_kept", branch_count, saved_bc);
    chk("flush_mc_kept", mispredict_count, saved_mc);
    $display("flush: bc=%0d mc=%0d pulses=%0d", branch_count, mispredict_count, pulses);

    // Saturation: 20 mispredicted branches on the 4-bit counter instance.
    do_reset();
    idx = 0;
    for (int c = 0; c < 60; c++) begin
      if (idx < 20) step(1'b1, PC_W'(idx), 1'b0, 1'b1, 1'b0);
      else          step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (accepted) idx++;
    end
    chk("sat_bc_stop", s_bc, 15);
    chk("sat_mc_stop", s_mc, 15);
    chk("wide_bc_20", branch_count, 20);
    $display("saturate: wide bc=%0d narrow bc=%0d mc=%0d", branch_count, s_bc, s_mc);

    // Asynchronous reset in the middle of a strobe with entries queued.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, PC_W'(10'h0A0 + i), 1'b1, 1'b0, 1'b0);
    chk("areset_pre_flag", upd_flag, 1);
    res_valid = 0;
    #2;
    rst = 1'b0;
    #1;
    chk("areset_flag",  upd_flag, 0);
    chk("areset_pc",    upd_pc, 0);
    chk("areset_taken", upd_taken, 0);
    chk("areset_busy",  busy, 0);
    chk("areset_bc",    branch_count, 0);
    chk("areset_mc",    mispredict_count, 0);
    chk("areset_ready", res_ready, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (upd_flag) pulses++;
    end
    chk("areset_no_pulses", pulses, 0);
    chk("areset_ready_after", ready_seen, 1);
    $display("async reset: pulses=%0d ready=%0b", pulses, ready_seen);

    // Random traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 9) < 7, PC_W'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 19) == 0);
    end
    $display("random: bc=%0d mc=%0d", branch_count, mispredict_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
